// File: rtl/rot_stage_pipe.sv
// Registered rotate pipeline: STAGES valid/ready stages, each rotating its word by ROT bits
// in the direction carried with the word, plus a delivered-word counter.
module rot_stage_pipe #(
    parameter int WIDTH  = 32,
    parameter int ROT    = 16,
    parameter int STAGES = 3,
    parameter int CNTW   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_dir,
    output logic [CNTW-1:0]  out_count
);

    // A right rotate by ROT is a left rotate by WIDTH-ROT; ROT=0 collapses to identity.
    localparam int ROT_L = ROT;
    localparam int ROT_R = (WIDTH - ROT) % WIDTH;

    function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x, input logic d);
        logic [2*WIDTH-1:0] dbl;
        dbl = {x, x} << (d ? ROT_R : ROT_L);
        return dbl[2*WIDTH-1:WIDTH];
    endfunction

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] dir;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  dat [STAGES];

    // A stage loads when it is empty or its word moves on; resolved from the output backwards.
    always_comb begin
        logic adv_k;
        // NOTE: blocking assignments here are intentional: adv_k is a combinational temporary
        // carried down the loop, and every output gets a default first so no latch is inferred.
        load  = '0;
        adv_k = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = !vld[k] | adv_k;
            adv_k   = load[k];
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld[STAGES-1];
    assign out_data  = dat[STAGES-1];
    assign out_dir   = dir[STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld       <= '0;
            dir       <= '0;
            out_count <= '0;
            // NOTE: the data registers are cleared too, so out_data reads zero during and
            // after reset rather than exposing a stale word.
            for (int k = 0; k < STAGES; k++) dat[k] <= '0;
        end else begin
            if (load[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    dat[0] <= rot(in_data, in_dir);
                    dir[0] <= in_dir;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        dat[k] <= rot(dat[k-1], dir[k-1]);
                        dir[k] <= dir[k-1];
                    end
                end
            end
            if (vld[STAGES-1] && out_ready) out_count <= out_count + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_rot_stage_pipe.sv
// Self-checking bench for rot_stage_pipe: a default-parameter instance checked against a
// queue-based reference, plus three edge-parameter instances driven by the same stimulus.
module tb_rot_stage_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_dir = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic        in_ready, out_valid, out_dir;
    logic [31:0] out_data;
    logic [15:0] out_count;

    logic        r8_in_ready, r8_out_valid, r8_out_dir;
    logic [31:0] r8_out_data;
    logic [3:0]  r8_out_count;

    logic        r0_in_ready, r0_out_valid, r0_out_dir;
    logic [31:0] r0_out_data;
    logic [15:0] r0_out_count;

    logic        s1_in_ready, s1_out_valid, s1_out_dir;
    logic [31:0] s1_out_data;
    logic [15:0] s1_out_count;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          model_cnt = 0;
    bit          last_acc;
    logic [32:0] exp_q[$];

    rot_stage_pipe u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dir(in_dir), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dir(out_dir), .out_count(out_count)
    );

    rot_stage_pipe #(.WIDTH(32), .ROT(8), .STAGES(3), .CNTW(4)) u_r8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r8_in_ready),
        .in_data(in_data), .in_dir(in_dir), .out_valid(r8_out_valid), .out_ready(out_ready),
        .out_data(r8_out_data), .out_dir(r8_out_dir), .out_count(r8_out_count)
    );

    rot_stage_pipe #(.WIDTH(32), .ROT(0), .STAGES(2), .CNTW(16)) u_r0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r0_in_ready),
        .in_data(in_data), .in_dir(in_dir), .out_valid(r0_out_valid), .out_ready(out_ready),
        .out_data(r0_out_data), .out_dir(r0_out_dir), .out_count(r0_out_count)
    );

    rot_stage_pipe #(.WIDTH(32), .ROT(16), .STAGES(1), .CNTW(16)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_data(in_data), .in_dir(in_dir), .out_valid(s1_out_valid), .out_ready(out_ready),
        .out_data(s1_out_data), .out_dir(s1_out_dir), .out_count(s1_out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Net effect of the pipe: rotate by `total` bits, left (right=0) or right (right=1).
    function automatic logic [31:0] ref_rot(input logic [31:0] x, input logic right, input int total);
        int          amt;
        logic [31:0] r;
        amt = total % 32;
        if (right) amt = (32 - amt) % 32;
        r = '0;
        for (int i = 0; i < 32; i++) r[(i + amt) % 32] = x[i];
        return r;
    endfunction

    // One clock: resolve handshakes at the falling edge, score the main instance, then step.
    task automatic tick();
        logic [32:0] e;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_cmp++;
            model_cnt++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL sb_unexpected: got data=%h dir=%b, expected no word", out_data, out_dir);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_dir} !== e) begin
                    n_mis++;
                    $display("FAIL sb_word: got data=%h dir=%b, expected data=%h dir=%b",
                             out_data, out_dir, e[32:1], e[0]);
                end
            end
        end
        if (last_acc) exp_q.push_back({ref_rot(in_data, in_dir, 48), in_dir});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #3;
        reset = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && c < budget) begin
            tick();
            c++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || out_valid) begin
            n_mis++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_dir !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_outputs: got v=%b d=%h dir=%b, expected 0/0/0", out_valid, out_data, out_dir);
        end
        n_cmp++;
        if (out_count !== 16'h0) begin
            n_mis++;
            $display("FAIL reset_count: got %0d expected 0", out_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || s1_in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready, s1_in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || r8_out_valid !== 1'b0 || r0_out_valid !== 1'b0 || s1_out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_out_valid: got %b%b%b%b expected 0000", out_valid, r8_out_valid, r0_out_valid, s1_out_valid);
        end
    endtask

    task automatic test_directed();
        reset_dut();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_dir = 1'b0;
        in_data = 32'h89a14fab;
        tick();
        in_data = 32'hf4c11a42;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h4fab89a1) begin
            n_mis++;
            $display("FAIL directed_w0: got v=%b d=%h expected v=1 d=4fab89a1", out_valid, out_data);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h1a42f4c1) begin
            n_mis++;
            $display("FAIL directed_w1: got v=%b d=%h expected v=1 d=1a42f4c1", out_valid, out_data);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_count !== 16'd2) begin
            n_mis++;
            $display("FAIL directed_count: got v=%b cnt=%0d expected v=0 cnt=2", out_valid, out_count);
        end
    endtask

    task automatic test_rot8_dir();
        reset_dut();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h12345678;
        in_dir = 1'b0;
        tick();
        in_dir = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (r8_out_valid !== 1'b1 || r8_out_data !== 32'h78123456 || r8_out_dir !== 1'b0) begin
            n_mis++;
            $display("FAIL rot8_left: got v=%b d=%h dir=%b expected 1/78123456/0", r8_out_valid, r8_out_data, r8_out_dir);
        end
        tick();
        n_cmp++;
        if (r8_out_valid !== 1'b1 || r8_out_data !== 32'h34567812 || r8_out_dir !== 1'b1) begin
            n_mis++;
            $display("FAIL rot8_right: got v=%b d=%h dir=%b expected 1/34567812/1", r8_out_valid, r8_out_data, r8_out_dir);
        end
        drain(10);
    endtask

    task automatic test_backpressure();
        logic [31:0] w [5];
        logic        wd[5];
        logic [31:0] hold;
        int          idx;
        int          c;
        for (int i = 0; i < 5; i++) begin
            w[i]  = $urandom();
            wd[i] = 1'($urandom_range(0, 1));
        end
        reset_dut();
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = w[idx];
            in_dir = wd[idx];
            tick();
            if (last_acc) idx++;
        end
        n_cmp++;
        if (idx !== 3) begin
            n_mis++;
            $display("FAIL bp_accepted: got %0d expected 3", idx);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL bp_in_ready: got %b expected 0", in_ready);
        end
        hold = out_data;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== hold || out_data !== ref_rot(w[0], wd[0], 48)) begin
            n_mis++;
            $display("FAIL bp_stable: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, ref_rot(w[0], wd[0], 48));
        end
        out_ready = 1'b1;
        c = 0;
        while (idx < 5 && c < 20) begin
            in_valid = 1'b1;
            in_data = w[idx];
            in_dir = wd[idx];
            tick();
            if (last_acc) idx++;
            c++;
        end
        drain(20);
        n_cmp++;
        if (out_count !== 16'd5) begin
            n_mis++;
            $display("FAIL bp_count: got %0d expected 5", out_count);
        end
    endtask

    task automatic test_reset_midflight();
        reset_dut();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = $urandom() | 32'h1;
        in_dir = 1'b0;
        tick();
        in_data = $urandom() | 32'h1;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_mis++;
            $display("FAIL mid_precond: got out_valid=%b expected 1", out_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_dir !== 1'b0) begin
            n_mis++;
            $display("FAIL mid_async_clear: got v=%b d=%h dir=%b expected 0/0/0", out_valid, out_data, out_dir);
        end
        #2;
        reset = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_count !== 16'h0) begin
            n_mis++;
            $display("FAIL mid_after_release: got rdy=%b cnt=%0d expected 1/0", in_ready, out_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_mis++;
                $display("FAIL mid_stale: got out_valid=%b d=%h expected 0", out_valid, out_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = $urandom();
            in_dir = 1'($urandom_range(0, 1));
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_mis++;
                $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (out_count !== 16'd20 || out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL b2b_throughput: got cnt=%0d v=%b expected 20/0", out_count, out_valid);
        end
    endtask

    task automatic test_bubbles_random();
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            in_valid = (i < 150) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
            in_data = $urandom();
            in_dir = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain(40);
        n_cmp++;
        if (out_count !== 16'(model_cnt)) begin
            n_mis++;
            $display("FAIL rand_count: got %0d expected %0d", out_count, model_cnt);
        end
    endtask

    task automatic test_edge_params();
        logic [31:0] w [8];
        logic        wd[8];
        int          idx;
        for (int i = 0; i < 8; i++) begin
            w[i]  = $urandom();
            wd[i] = 1'($urandom_range(0, 1));
        end
        reset_dut();
        out_ready = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            in_valid = (t <= 8);
            in_data = (t <= 8) ? w[t-1] : 32'h0;
            in_dir = (t <= 8) ? wd[t-1] : 1'b0;
            tick();
            idx = t - 1;
            n_cmp++;
            if (s1_out_valid !== (idx < 8)) begin
                n_mis++;
                $display("FAIL s1_valid: t=%0d got %b expected %b", t, s1_out_valid, (idx < 8));
            end else if (idx < 8 && ({s1_out_data, s1_out_dir} !== {ref_rot(w[idx], wd[idx], 16), wd[idx]})) begin
                n_mis++;
                $display("FAIL s1_data: t=%0d got %h expected %h", t, s1_out_data, ref_rot(w[idx], wd[idx], 16));
            end
            idx = t - 2;
            n_cmp++;
            if (r0_out_valid !== (idx >= 0 && idx < 8)) begin
                n_mis++;
                $display("FAIL r0_valid: t=%0d got %b expected %b", t, r0_out_valid, (idx >= 0 && idx < 8));
            end else if (idx >= 0 && idx < 8 && ({r0_out_data, r0_out_dir} !== {w[idx], wd[idx]})) begin
                n_mis++;
                $display("FAIL r0_identity: t=%0d got %h expected %h", t, r0_out_data, w[idx]);
            end
            idx = t - 3;
            n_cmp++;
            if (r8_out_valid !== (idx >= 0 && idx < 8)) begin
                n_mis++;
                $display("FAIL r8_valid: t=%0d got %b expected %b", t, r8_out_valid, (idx >= 0 && idx < 8));
            end else if (idx >= 0 && idx < 8 && ({r8_out_data, r8_out_dir} !== {ref_rot(w[idx], wd[idx], 24), wd[idx]})) begin
                n_mis++;
                $display("FAIL r8_data: t=%0d got %h expected %h", t, r8_out_data, ref_rot(w[idx], wd[idx], 24));
            end
        end
        drain(10);
    endtask

    task automatic test_counter_wrap();
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data = $urandom();
            in_dir = 1'($urandom_range(0, 1));
            tick();
        end
        drain(10);
        n_cmp++;
        if (r8_out_count !== 4'd1) begin
            n_mis++;
            $display("FAIL cnt_wrap: got %0d expected 1", r8_out_count);
        end
        n_cmp++;
        if (out_count !== 16'd17) begin
            n_mis++;
            $display("FAIL cnt_main: got %0d expected 17", out_count);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rot8_dir();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        test_bubbles_random();
        test_edge_params();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
